// File: rtl/sar_search_4_if.sv
// Handshake and comparator-loop bundle between the SAR search engine and its requester/comparator.
interface sar_search_4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] guess;
    logic             cmp_a_big;
    logic             cmp_b_big;
    logic             cmp_a_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    // Requester side: issues start, closes the loop through the comparator flags.
    modport master (
        output start,
        output cmp_a_big,
        output cmp_b_big,
        output cmp_a_b,
        input  guess,
        input  busy,
        input  done,
        input  result,
        input  error
    );

    // Search engine side.
    modport slave (
        input  start,
        input  cmp_a_big,
        input  cmp_b_big,
        input  cmp_a_b,
        output guess,
        output busy,
        output done,
        output result,
        output error
    );
endinterface

// File: rtl/sar_search_4.sv
// Successive-approximation search: probes MSB-first through an external comparator to recover its b operand.
module sar_search_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sar_search_4_if.slave bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TRIAL_TOP = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_dec;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [2:0]       flags;
    logic             flags_onehot;
    logic             probe_exit;

    assign flags        = {bus.cmp_a_big, bus.cmp_b_big, bus.cmp_a_b};
    assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    // Bad flags, a hit, or the last bit all end the search this cycle.
    assign probe_exit   = !flags_onehot || bus.cmp_a_b || (idx_q == '0);
    assign idx_dec      = idx_q - IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_PROBE;
            S_PROBE: if (probe_exit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        trial_d  = trial_q;
        idx_d    = idx_q;
        result_d = result_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    trial_d = TRIAL_TOP;
                    idx_d   = IDX_TOP;
                    error_d = 1'b0;
                end
            end
            S_PROBE: begin
                if (!flags_onehot) begin
                    result_d = trial_q;
                    error_d  = 1'b1;
                end else if (bus.cmp_a_b) begin
                    result_d = trial_q;
                    error_d  = 1'b0;
                end else if (idx_q == '0) begin
                    // Guess < target on the LSB cannot happen with a consistent comparator.
                    if (bus.cmp_a_big) begin
                        result_d = trial_q & ~WIDTH'(1);
                        error_d  = 1'b0;
                    end else begin
                        result_d = trial_q;
                        error_d  = 1'b1;
                    end
                end else begin
                    if (bus.cmp_a_big) trial_d[idx_q] = 1'b0;
                    trial_d[idx_dec] = 1'b1;
                    idx_d            = idx_dec;
                end
            end
            default: ;
        endcase
        guess_d = (state_d == S_PROBE) ? trial_d : '0;
        busy_d  = (state_d == S_PROBE);
        done_d  = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trial_q  <= '0;
            idx_q    <= '0;
            guess_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            trial_q  <= trial_d;
            idx_q    <= idx_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_sar_search_4.sv
// Randomized self-checking bench for sar_search_4 with a behavioural comparator and binary-search model.
module tb_sar_search_4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sar_search_4_if #(.WIDTH(4)) bus ();

    sar_search_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         target;
    int         fault_mode;   // 0 none, 1 all flags low, 2 b_big forced
    logic [3:0] fault_guess;
    int         exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Ideal comparator with optional fault injection on one specific probe value.
    always_comb begin
        bus.cmp_a_big = (int'(bus.guess) > target);
        bus.cmp_b_big = (int'(bus.guess) < target);
        bus.cmp_a_b   = (int'(bus.guess) == target);
        if (bus.busy && bus.guess == fault_guess && fault_mode == 1) begin
            bus.cmp_a_big = 1'b0;
            bus.cmp_b_big = 1'b0;
            bus.cmp_a_b   = 1'b0;
        end else if (bus.busy && bus.guess == fault_guess && fault_mode == 2) begin
            bus.cmp_a_big = 1'b0;
            bus.cmp_b_big = 1'b1;
            bus.cmp_a_b   = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Expected probe sequence: binary search around the midpoint, halving the step each probe.
    task automatic build_model(input int t);
        int g;
        int step;
        exp_q.delete();
        g    = 8;
        step = 4;
        while (1) begin
            exp_q.push_back(g);
            if (g == t || step == 0) break;
            g    = (g > t) ? g - step : g + step;
            step = step / 2;
        end
    endtask

    task automatic run_search(input int t, input int fmode, input logic [3:0] fg, input bit noise);
        int  nprobe;
        int  lat;
        bit  seen;
        int  exp_res;
        int  exp_err;
        target      = t;
        fault_mode  = fmode;
        fault_guess = fg;
        build_model(t);
        exp_res = t;
        exp_err = 0;
        if (fmode != 0) begin
            while (exp_q.size() > 1 && exp_q[exp_q.size()-1] != int'(fg)) void'(exp_q.pop_back());
            exp_res = int'(fg);
            exp_err = 1;
        end
        nprobe = 0;
        lat    = 0;
        seen   = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.done) begin
                seen = 1;
                lat  = c;
                if (noise) bus.start = 1'b1;
                break;
            end
            chk("busy_in_probe", 32'(bus.busy), 32'd1);
            if (nprobe < exp_q.size()) chk("guess", 32'(bus.guess), 32'(exp_q[nprobe]));
            else chk("extra_probe", 32'(nprobe), 32'(exp_q.size()));
            nprobe++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("probe_count", 32'(nprobe), 32'(exp_q.size()));
        chk("latency", 32'(lat), 32'(exp_q.size() + 1));
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_guess", 32'(bus.guess), 32'd0);
        chk("result", 32'(bus.result), 32'(exp_res));
        chk("error", 32'(bus.error), 32'(exp_err));
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("held_result", 32'(bus.result), 32'(exp_res));
        @(negedge clk);
        chk("no_restart", 32'(bus.busy), 32'd0);
        fault_mode = 0;
    endtask

    initial begin
        bit seen;
        bus.start   = 1'b0;
        target      = 0;
        fault_mode  = 0;
        fault_guess = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_guess", 32'(bus.guess), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: early exit, full walks, zero target
        run_search(8, 0, 4'd0, 0);
        run_search(5, 0, 4'd0, 0);
        run_search(15, 0, 4'd0, 0);
        run_search(0, 0, 4'd0, 0);

        // Fault injection: no flags on second probe, b_big on the LSB probe
        run_search(5, 1, 4'd4, 0);
        run_search(0, 2, 4'd1, 0);
        run_search(5, 0, 4'd0, 0);

        // Start noise during PROBE and DONE
        run_search(3, 0, 4'd0, 1);
        run_search(12, 0, 4'd0, 1);

        // Exhaustive sweep
        for (int t = 0; t < 16; t++) run_search(t, 0, 4'd0, 0);

        // Start held high: back-to-back with one IDLE cycle
        target     = 5;
        fault_mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1; break; end
        end
        chk("hold_done", 32'(seen), 32'd1);
        @(negedge clk);
        chk("hold_idle_busy", 32'(bus.busy), 32'd0);
        chk("hold_idle_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("hold_restart_busy", 32'(bus.busy), 32'd1);
        chk("hold_restart_guess", 32'(bus.guess), 32'd8);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1; break; end
        end
        chk("hold_done2", 32'(seen), 32'd1);
        chk("hold_result", 32'(bus.result), 32'd5);
        @(negedge clk);
        @(negedge clk);

        // Reset mid-PROBE aborts without done
        target = 15;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_guess", 32'(bus.guess), 32'd0);
        chk("midrst_result", 32'(bus.result), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_error", 32'(bus.error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus.done), 32'd0);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
        end

        // Randomized searches with random idle gaps and occasional start noise
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_search(int'($urandom_range(0, 15)), 0, 4'd0, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
